btn_mux_pwm: RTL and testbench

//  Parametrised board-level gate exerciser: debounces N_CH data buttons plus STEP/MODE buttons,

---
 rtl/ice_io_pkg.sv | 18 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/btn_mux_pwm.sv | 136 +++++++++++++
 tb/tb_btn_mux_pwm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ice_io_pkg.sv
// Shared constants and helpers for the button/LED exerciser blocks.
package ice_io_pkg;

    localparam logic MODE_MUX    = 1'b0;
    localparam logic MODE_DMUX   = 1'b1;
    localparam int   SYNC_STAGES = 2;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } breathe_dir_e;

    // Modulo-n increment; keeps non-power-of-2 selects inside 0..n-1.
    function automatic int wrap_inc(input int v, input int n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: SYNC_STAGES-deep synchroniser followed by a counting debouncer.
module btn_debounce
    import ice_io_pkg::*;
#(
    parameter int DB_W = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic db
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic [DB_W-1:0]        cnt;
    logic                   stable;
    logic                   synced;

    assign synced = sync_pipe[SYNC_STAGES-1];

    // Counter only runs while the synced level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the qualification window.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_pipe <= '0;
            cnt       <= '0;
            stable    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], raw};
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == '1) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign db = stable;

endmodule

// File: rtl/btn_mux_pwm.sv
// Button-driven mux/dmux exerciser with PWM-dimmed LEDs.
// Define PWM_BREATHE_EN to replace the fixed duty with a triangle "breathing" ramp.
module btn_mux_pwm
    import ice_io_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int PWM_W = 8,
    parameter int DUTY  = 8,
    parameter int DB_W  = 16,
    parameter int BR_W  = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [N_CH-1:0]          DIN,
    input  logic                     STEP,
    input  logic                     MODE,
    output logic [N_CH-1:0]          LED,
    output logic [$clog2(N_CH)-1:0]  SEL
);

    localparam int               SEL_W  = $clog2(N_CH);
    localparam logic [PWM_W:0]   DUTY_V = (PWM_W + 1)'(DUTY);

    logic [N_CH-1:0]  din_db;
    logic             step_db;
    logic             mode_db;
    logic             step_q;
    logic             step_pulse;
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  pat;
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W:0]   duty;
    logic             pwm_on;
    logic             pwm_wrap;

    for (genvar i = 0; i < N_CH; i++) begin : g_din
        btn_debounce #(.DB_W(DB_W)) u_din_db (
            .CLK   (CLK),
            .RST_N (RST_N),
            .raw   (DIN[i]),
            .db    (din_db[i])
        );
    end

    btn_debounce #(.DB_W(DB_W)) u_step_db (
        .CLK   (CLK),
        .RST_N (RST_N),
        .raw   (STEP),
        .db    (step_db)
    );

    btn_debounce #(.DB_W(DB_W)) u_mode_db (
        .CLK   (CLK),
        .RST_N (RST_N),
        .raw   (MODE),
        .db    (mode_db)
    );

    // A held STEP produces a single pulse: only the debounced rising edge counts.
    assign step_pulse = step_db & ~step_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step_q <= 1'b0;
            sel    <= '0;
        end else begin
            step_q <= step_db;
            if (step_pulse)
                sel <= SEL_W'(wrap_inc(int'(sel), N_CH));
        end
    end

    always_comb begin
        pat = '0;
        if (mode_db == MODE_DMUX)
            pat[sel] = din_db[0];
        else
            pat[0] = din_db[sel];
    end

    assign pwm_wrap = (pwm_cnt == '1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 1'b1;
    end

`ifdef PWM_BREATHE_EN
    logic [BR_W-1:0] br_cnt;
    breathe_dir_e    dir;

    // Duty only moves on the period boundary so no period is ever cut short.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            br_cnt <= '0;
            duty   <= '0;
            dir    <= DIR_UP;
        end else if (pwm_wrap) begin
            if (br_cnt != '1) begin
                br_cnt <= br_cnt + 1'b1;
            end else begin
                br_cnt <= '0;
                if (DUTY_V != '0) begin
                    if (dir == DIR_UP) begin
                        duty <= duty + 1'b1;
                        if (duty + 1'b1 == DUTY_V)
                            dir <= DIR_DOWN;
                    end else begin
                        duty <= duty - 1'b1;
                        if (duty == (PWM_W + 1)'(1))
                            dir <= DIR_UP;
                    end
                end
            end
        end
    end
`else
    assign duty = DUTY_V;
`endif

    // One extra compare bit lets a duty of 2**PWM_W mean fully on.
    assign pwm_on = ({1'b0, pwm_cnt} < duty);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LED <= '0;
            SEL <= '0;
        end else begin
            LED <= pwm_on ? pat : '0;
            SEL <= sel;
        end
    end

endmodule

// File: tb/tb_btn_mux_pwm.sv
// Bench for btn_mux_pwm: three instances (DUTY 4, 8, 0) share one set of buttons.
module tb_btn_mux_pwm;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] DIN = '0;
    logic       STEP = 1'b0;
    logic       MODE = 1'b0;
    logic [2:0] led_m, led_on, led_off;
    logic [1:0] sel_m, sel_on, sel_off;

    always #5 CLK = ~CLK;

    btn_mux_pwm #(.N_CH(3), .PWM_W(3), .DUTY(4), .DB_W(2), .BR_W(1)) u_main (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .STEP(STEP), .MODE(MODE), .LED(led_m), .SEL(sel_m));
    btn_mux_pwm #(.N_CH(3), .PWM_W(3), .DUTY(8), .DB_W(2), .BR_W(1)) u_on (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .STEP(STEP), .MODE(MODE), .LED(led_on), .SEL(sel_on));
    btn_mux_pwm #(.N_CH(3), .PWM_W(3), .DUTY(0), .DB_W(2), .BR_W(1)) u_off (
        .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .STEP(STEP), .MODE(MODE), .LED(led_off), .SEL(sel_off));

    // Posedges since reset release; sample k reflects pwm phase (k-1) mod 8.
    int cyc;
    always @(posedge CLK or negedge RST_N)
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        int         dut;
        logic [2:0] led;
        bit         use_sel;
        logic [1:0] sel;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0] din;
        logic       mode;
        int         presses;
        logic [1:0] sel;
        logic [2:0] pat;
    } vec_t;
    vec_t vt[12];

    function automatic int exp_duty(input int p, input int d);
`ifdef PWM_BREATHE_EN
        int t;
        if (d == 0) return 0;
        t = (p / 2) % (2 * d);
        return (t <= d) ? t : 2 * d - t;
`else
        return d + 0 * p;
`endif
    endfunction

    function automatic bit on_now(input int d);
        int k;
        k = cyc - 1;
        return (k % 8) < exp_duty(k / 8, d);
    endfunction

    task automatic push(input string name, input int dut, input logic [2:0] led,
                        input bit use_sel, input logic [1:0] sel);
        exp_t e;
        e.name = name; e.dut = dut; e.led = led; e.use_sel = use_sel; e.sel = sel;
        sb.push_back(e);
    endtask

    task automatic push_pat(input string name, input int dut, input int d,
                            input logic [2:0] pat, input logic [1:0] sel);
        push(name, dut, on_now(d) ? pat : 3'b000, 1'b1, sel);
    endtask

    task automatic drain();
        exp_t       e;
        logic [2:0] al;
        logic [1:0] as;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin al = led_m;   as = sel_m;   end
                1:       begin al = led_on;  as = sel_on;  end
                default: begin al = led_off; as = sel_off; end
            endcase
            n_run++;
            if (al !== e.led || (e.use_sel && as !== e.sel)) begin
                n_fail++;
                $display("FAIL %s dut%0d cyc%0d: LED=%b SEL=%0d, expected LED=%b SEL=%0d",
                         e.name, e.dut, cyc, al, as, e.led, e.sel);
            end
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press();
        STEP = 1'b1;
        tick(10);
        STEP = 1'b0;
        tick(10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        vt[0]  = '{3'b100, 1'b0, 2, 2'd2, 3'b001};
        vt[1]  = '{3'b100, 1'b0, 1, 2'd0, 3'b000};
        vt[2]  = '{3'b001, 1'b0, 0, 2'd0, 3'b001};
        vt[3]  = '{3'b010, 1'b0, 1, 2'd1, 3'b001};
        vt[4]  = '{3'b001, 1'b1, 0, 2'd1, 3'b010};
        vt[5]  = '{3'b000, 1'b1, 0, 2'd1, 3'b000};
        vt[6]  = '{3'b001, 1'b1, 1, 2'd2, 3'b100};
        vt[7]  = '{3'b111, 1'b1, 1, 2'd0, 3'b001};
        vt[8]  = '{3'b110, 1'b1, 0, 2'd0, 3'b000};
        vt[9]  = '{3'b011, 1'b0, 2, 2'd2, 3'b000};
        vt[10] = '{3'b101, 1'b0, 0, 2'd2, 3'b001};
        vt[11] = '{3'b011, 1'b1, 1, 2'd0, 3'b001};

        // Reset state
        tick(3);
        push("reset", 0, 3'b000, 1'b1, 2'd0);
        push("reset", 1, 3'b000, 1'b1, 2'd0);
        push("reset", 2, 3'b000, 1'b1, 2'd0);
        drain();
        RST_N = 1'b1;

        // 3-cycle glitch on DIN[0] must never be accepted
        DIN = 3'b001;
        tick(3);
        DIN = 3'b000;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            push_pat("db_glitch", 1, 8, 3'b000, 2'd0);
            drain();
        end

        // Held DIN[0]: debounced after 6 edges, visible on LED one edge later
        DIN = 3'b001;
        for (int k = 1; k <= 9; k++) begin
            tick(1);
            push_pat("db_accept", 1, 8, (k >= 7) ? 3'b001 : 3'b000, 2'd0);
            drain();
        end

        // Mux/dmux table; last entry changes MODE and presses STEP together
        foreach (vt[i]) begin
            DIN  = vt[i].din;
            MODE = vt[i].mode;
            for (int p = 0; p < vt[i].presses; p++) press();
            tick(10);
            for (int s = 0; s < 8; s++) begin
                tick(1);
                push_pat($sformatf("vec%0d", i), 0, 4, vt[i].pat, vt[i].sel);
                push_pat($sformatf("vec%0d", i), 1, 8, vt[i].pat, vt[i].sel);
                push("dark", 2, 3'b000, 1'b1, vt[i].sel);
                drain();
            end
        end

        // STEP held for 40 cycles advances select exactly once (dmux, din[0]=1)
        STEP = 1'b1;
        tick(40);
        push_pat("held_step", 1, 8, 3'b010, 2'd1);
        drain();
        STEP = 1'b0;
        tick(20);
        push_pat("held_release", 1, 8, 3'b010, 2'd1);
        drain();

        // Asynchronous reset mid-run with all buttons pressed
        DIN  = 3'b111;
        MODE = 1'b0;
        tick(10);
        push_pat("pre_reset", 1, 8, 3'b001, 2'd1);
        drain();
        #2;
        RST_N = 1'b0;
        #1;
        push("async_rst", 0, 3'b000, 1'b1, 2'd0);
        push("async_rst", 1, 3'b000, 1'b1, 2'd0);
        drain();
        tick(2);
        push("rst_hold", 1, 3'b000, 1'b1, 2'd0);
        drain();
        RST_N = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            push_pat("redebounce", 1, 8, (k >= 7) ? 3'b001 : 3'b000, 2'd0);
            drain();
        end

        // 20 PWM periods: per-sample shape and per-period on-time
        for (int p = 0; p < 20; p++) begin
            cnt = 0;
            for (int s = 0; s < 8; s++) begin
                tick(1);
                if (led_m != 3'b000) cnt++;
                push_pat("pwm_main", 0, 4, 3'b001, 2'd0);
                push_pat("pwm_full", 1, 8, 3'b001, 2'd0);
                push("pwm_dark", 2, 3'b000, 1'b1, 2'd0);
                drain();
            end
            check_int("on_time", cnt, exp_duty((cyc - 1) / 8, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
